pwm_multi: RTL

Multi-channel, parametrised PWM generator. All channels share one true-period counter, and each channel has its own duty and polarity. Period, duty, polarity and mode are double-buffered, so updates take effect only at a period boundary (glitch-free). Supports edge-aligned and center-aligned modes. Drives motor, LED and backlight outputs on the GW1NR fabric from the ESP32 control interface.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_ch.sv | 34 +++
 rtl/pwm_multi.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
package pwm_pkg;

  localparam logic PWM_EDGE   = 1'b0;
  localparam logic PWM_CENTER = 1'b1;

  localparam logic DIR_UP     = 1'b0;
  localparam logic DIR_DOWN   = 1'b1;

  // LSB of channel ch inside a packed per-channel vector of width-bit fields.
  function automatic int duty_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/pwm_ch.sv
// One PWM channel: duty compare against the shared counter, polarity,
// live output enable and the output register.
module pwm_ch #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] cnt,
  input  logic [N-1:0] duty_a,
  input  logic         pol_a,
  input  logic         ch_en,
  output logic         pwm_out
);

  logic raw;
  logic pwm_d;
  logic pwm_q;

  always_comb begin
    raw   = (cnt < duty_a);
    pwm_d = ch_en ? (raw ^ pol_a) : pol_a;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/center-aligned period counter with
// double-buffered period/duty/polarity/mode, swapped only at period boundaries.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int N   = 16,
  parameter int NCH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             mode_in,
  input  logic [N-1:0]     period_in,
  input  logic [NCH*N-1:0] duty_in,
  input  logic [NCH-1:0]   pol_in,
  input  logic [NCH-1:0]   ch_en,
  output logic [NCH-1:0]   pwm_out,
  output logic [N-1:0]     cnt_out,
  output logic             period_strobe,
  output logic             upd_done
);

  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0]     cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             run_q, run_d;
  logic             strobe_q, strobe_d;
  logic             upd_q, upd_d;

  logic [N-1:0]     period_a_q, period_a_d;
  logic [NCH*N-1:0] duty_a_q, duty_a_d;
  logic [NCH-1:0]   pol_a_q, pol_a_d;
  logic             mode_a_q, mode_a_d;

  logic [N-1:0]     period_p_q, period_p_d;
  logic [NCH*N-1:0] duty_p_q, duty_p_d;
  logic [NCH-1:0]   pol_p_q, pol_p_d;
  logic             mode_p_q, mode_p_d;
  logic             pend_q, pend_d;

  logic             boundary;
  logic             wrap;
  logic             transfer;

  always_comb begin
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    run_d      = run_q;
    period_a_d = period_a_q;
    duty_a_d   = duty_a_q;
    pol_a_d    = pol_a_q;
    mode_a_d   = mode_a_q;
    period_p_d = period_p_q;
    duty_p_d   = duty_p_q;
    pol_p_d    = pol_p_q;
    mode_p_d   = mode_p_q;
    pend_d     = pend_q;

    // Center boundary is the step that lands back on 0; with period 1 that
    // step happens straight from the top, before the direction ever flips.
    if (mode_a_q == PWM_EDGE) begin
      boundary = (cnt_q == period_a_q);
    end else begin
      boundary = (period_a_q == '0) ||
                 ((cnt_q == CNT_ONE) && ((dir_q == DIR_DOWN) || (period_a_q == CNT_ONE)));
    end

    // The first counted cycle after en rises is treated as a period start.
    wrap     = en && (!run_q || boundary);
    transfer = pend_q && (!en || wrap);

    if (!en) begin
      cnt_d = '0;
      dir_d = DIR_UP;
      run_d = 1'b0;
    end else begin
      run_d = 1'b1;
      if (wrap) begin
        cnt_d = '0;
        dir_d = DIR_UP;
      end else if (mode_a_q == PWM_EDGE) begin
        cnt_d = cnt_q + 1'b1;
      end else if (dir_q == DIR_UP) begin
        if (cnt_q == period_a_q) begin
          dir_d = DIR_DOWN;
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    if (transfer) begin
      period_a_d = period_p_q;
      duty_a_d   = duty_p_q;
      pol_a_d    = pol_p_q;
      mode_a_d   = mode_p_q;
      pend_d     = 1'b0;
    end

    // A load on the transfer cycle re-arms the pending set with the new values.
    if (load) begin
      period_p_d = period_in;
      duty_p_d   = duty_in;
      pol_p_d    = pol_in;
      mode_p_d   = mode_in;
      pend_d     = 1'b1;
    end

    strobe_d = wrap;
    upd_d    = transfer;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      dir_q      <= DIR_UP;
      run_q      <= 1'b0;
      strobe_q   <= 1'b0;
      upd_q      <= 1'b0;
      period_a_q <= '0;
      duty_a_q   <= '0;
      pol_a_q    <= '0;
      mode_a_q   <= PWM_EDGE;
      period_p_q <= '0;
      duty_p_q   <= '0;
      pol_p_q    <= '0;
      mode_p_q   <= PWM_EDGE;
      pend_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      run_q      <= run_d;
      strobe_q   <= strobe_d;
      upd_q      <= upd_d;
      period_a_q <= period_a_d;
      duty_a_q   <= duty_a_d;
      pol_a_q    <= pol_a_d;
      mode_a_q   <= mode_a_d;
      period_p_q <= period_p_d;
      duty_p_q   <= duty_p_d;
      pol_p_q    <= pol_p_d;
      mode_p_q   <= mode_p_d;
      pend_q     <= pend_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    pwm_ch #(.N(N)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .cnt     (cnt_q),
      .duty_a  (duty_a_q[duty_lsb(k, N) +: N]),
      .pol_a   (pol_a_q[k]),
      .ch_en   (ch_en[k]),
      .pwm_out (pwm_out[k])
    );
  end

  assign cnt_out       = cnt_q;
  assign period_strobe = strobe_q;
  assign upd_done      = upd_q;

endmodule
